// File: rtl/ptr_sync_flag.sv
// Empty/full flag generator for one side of a dual-clock FIFO: synchronizes the
// remote Gray pointer and derives the registered flag, almost flag and fill level.
`timescale 1ns/1ps
module ptr_sync_flag #(
  parameter int DEPTH  = 8,
  parameter int MODE   = 0,
  parameter int THRESH = 1,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic [PW-1:0] ptr_next,
  input  logic [PW-1:0] ptr_remote,
  output logic          flag,
  output logic          almost,
  output logic [PW-1:0] level
);

  localparam int HALF = DEPTH / 2;
  localparam logic [PW:0] LO_LIM = (PW+1)'(THRESH);
  localparam logic [PW:0] HI_LIM = (PW+1)'(HALF - THRESH);
  // Full means the pointers differ by exactly DEPTH/2, i.e. the top two Gray bits flipped.
  localparam int unsigned MASK_I = 3 << (PW - 2);
  localparam logic [PW-1:0] FULL_MASK = MASK_I[PW-1:0];
  localparam logic FLAG_RST   = (MODE == 0);
  localparam logic ALMOST_RST = (MODE == 0) || (THRESH >= HALF);

  logic [PW-1:0] sync1_q, sync1_d;
  logic [PW-1:0] sync2_q, sync2_d;
  logic          flag_q, flag_d;
  logic          almost_q, almost_d;
  logic [PW-1:0] level_q, level_d;
  logic [PW-1:0] lbin, rbin, occ;
  logic [PW:0]   occ_ext;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  always_comb begin
    sync1_d  = ptr_remote;
    sync2_d  = sync1_q;
    lbin     = gray2bin(ptr_next);
    rbin     = gray2bin(sync2_q);
    occ      = '0;
    flag_d   = 1'b0;
    almost_d = 1'b0;
    if (MODE == 0) begin
      occ      = rbin - lbin;
      occ_ext  = {1'b0, occ};
      flag_d   = (ptr_next == sync2_q);
      almost_d = (occ_ext <= LO_LIM);
    end else begin
      occ      = lbin - rbin;
      occ_ext  = {1'b0, occ};
      flag_d   = (ptr_next == (sync2_q ^ FULL_MASK));
      almost_d = (occ_ext >= HI_LIM);
    end
    level_d = occ;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      flag_q   <= FLAG_RST;
      almost_q <= ALMOST_RST;
      level_q  <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      flag_q   <= flag_d;
      almost_q <= almost_d;
      level_q  <= level_d;
    end
  end

  assign flag   = flag_q;
  assign almost = almost_q;
  assign level  = level_q;

endmodule

// File: tb/tb_ptr_sync_flag.sv
// Bench for ptr_sync_flag: one read-side and one write-side instance, directed
// scenarios followed by a random FIFO pointer walk, checked against a binary-pointer model.
`timescale 1ns/1ps
module tb_ptr_sync_flag;

  localparam int DEPTH  = 8;
  localparam int THRESH = 1;
  localparam int HALF   = DEPTH / 2;

  // clock / reset
  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  // binary pointers driven by the bench; DUTs see their Gray form
  int nx0 = 0, rm0 = 0, nx1 = 0, rm1 = 0;
  logic [2:0] pn0, pr0, pn1, pr1;
  logic       flag0, almost0, flag1, almost1;
  logic [2:0] level0, level1;

  function automatic logic [2:0] to_gray(input int b);
    logic [2:0] v;
    v = 3'(b);
    return v ^ (v >> 1);
  endfunction

  assign pn0 = to_gray(nx0);
  assign pr0 = to_gray(rm0);
  assign pn1 = to_gray(nx1);
  assign pr1 = to_gray(rm1);

  ptr_sync_flag #(.DEPTH(DEPTH), .MODE(0), .THRESH(THRESH)) dut0 (
    .clock(clock), .resetn(resetn), .ptr_next(pn0), .ptr_remote(pr0),
    .flag(flag0), .almost(almost0), .level(level0));

  ptr_sync_flag #(.DEPTH(DEPTH), .MODE(1), .THRESH(THRESH)) dut1 (
    .clock(clock), .resetn(resetn), .ptr_next(pn1), .ptr_remote(pr1),
    .flag(flag1), .almost(almost1), .level(level1));

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: remote values sampled at each edge; outputs after edge k
  // use the remote value sampled at edge k-2 (zero right after reset)
  int hist0[$];
  int hist1[$];

  function automatic int occ_of(input int mode, input int l, input int r);
    return (mode == 0) ? ((r - l) & (DEPTH - 1)) : ((l - r) & (DEPTH - 1));
  endfunction

  function automatic int flag_of(input int mode, input int occ);
    return (mode == 0) ? int'(occ == 0) : int'(occ == HALF);
  endfunction

  function automatic int almost_of(input int mode, input int occ);
    return (mode == 0) ? int'(occ <= THRESH) : int'(occ >= HALF - THRESH);
  endfunction

  task automatic cycle();
    int l0, l1, o0, o1;
    @(posedge clock);
    hist0.push_back(rm0);
    hist1.push_back(rm1);
    if (hist0.size() > 3) void'(hist0.pop_front());
    if (hist1.size() > 3) void'(hist1.pop_front());
    l0 = nx0;
    l1 = nx1;
    o0 = occ_of(0, l0, hist0[0]);
    o1 = occ_of(1, l1, hist1[0]);
    #1;
    check("rd_level",  int'(level0),  o0);
    check("rd_flag",   int'(flag0),   flag_of(0, o0));
    check("rd_almost", int'(almost0), almost_of(0, o0));
    check("wr_level",  int'(level1),  o1);
    check("wr_flag",   int'(flag1),   flag_of(1, o1));
    check("wr_almost", int'(almost1), almost_of(1, o1));
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    @(posedge clock);
    #1;
    check("rst_rd_flag",   int'(flag0),   1);
    check("rst_rd_almost", int'(almost0), 1);
    check("rst_rd_level",  int'(level0),  0);
    check("rst_wr_flag",   int'(flag1),   0);
    check("rst_wr_almost", int'(almost1), 0);
    check("rst_wr_level",  int'(level1),  0);
    check("rst_sync1",     int'(dut1.sync1_q), 0);
    check("rst_sync2",     int'(dut1.sync2_q), 0);
    hist0 = '{0, 0};
    hist1 = '{0, 0};
    resetn = 1'b1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  int wr = 0, rd = 0;

  initial begin
    // reset with arbitrary pointer values
    nx0 = int'($urandom_range(0, 7)); rm0 = int'($urandom_range(0, 7));
    nx1 = int'($urandom_range(0, 7)); rm1 = int'($urandom_range(0, 7));
    do_reset();
    nx0 = 0; rm0 = 0; nx1 = 0; rm1 = 0;
    settle(3);

    // write-side fill: level 1..4, almost at 3, full at 4
    for (int k = 1; k <= 4; k++) begin
      nx1 = k;
      cycle();
      check("fill_level", int'(level1), k);
      check("fill_almost", int'(almost1), int'(k >= 3));
      check("fill_flag", int'(flag1), int'(k == 4));
    end

    // read-side remote arrival: empty falls exactly 3 edges after the change
    rm0 = 1;
    cycle();
    check("arr_flag_e1", int'(flag0), 1);
    rm0 = 2;
    cycle();
    check("arr_flag_e2", int'(flag0), 1);
    cycle();
    check("arr_flag_e3", int'(flag0), 0);
    check("arr_level_e3", int'(level0), 1);
    check("arr_almost_e3", int'(almost0), 1);
    cycle();
    check("arr_level_e4", int'(level0), 2);
    check("arr_almost_e4", int'(almost0), 0);

    // wrap-around on the read side
    nx0 = 7; rm0 = 7;
    settle(3);
    check("wrap_flag_full", int'(flag0), 1);
    rm0 = 0;
    settle(3);
    check("wrap_level", int'(level0), 1);
    check("wrap_flag", int'(flag0), 0);
    nx0 = 0;
    cycle();
    check("wrap_level2", int'(level0), 0);
    check("wrap_flag2", int'(flag0), 1);

    // simultaneous local and remote step on the write side
    nx1 = 2; rm1 = 0;
    settle(3);
    check("sim_start", int'(level1), 2);
    nx1 = 3; rm1 = 1;
    cycle();
    check("sim_e1", int'(level1), 3);
    cycle();
    check("sim_e2", int'(level1), 3);
    cycle();
    check("sim_e3", int'(level1), 2);
    check("sim_flag", int'(flag1), 0);

    // reset while full
    nx1 = 4; rm1 = 0;
    settle(3);
    check("pre_rst_flag", int'(flag1), 1);
    check("pre_rst_level", int'(level1), 4);
    do_reset();

    // random FIFO walk: both instances watch the same write/read pointers
    wr = 0; rd = 0;
    nx0 = 0; rm0 = 0; nx1 = 0; rm1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        do_reset();
        wr = 0; rd = 0;
      end
      if ($urandom_range(0, 1) == 1 && ((wr - rd) & (DEPTH - 1)) < HALF) wr = (wr + 1) & (DEPTH - 1);
      if ($urandom_range(0, 2) == 0 && wr != rd) rd = (rd + 1) & (DEPTH - 1);
      nx0 = rd; rm0 = wr;
      nx1 = wr; rm1 = rd;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ptr_sync_flag.md
# ptr_sync_flag

Flag generator paired with `ptr_gen` in the dual-clock FIFO. It receives the Gray-coded pointer published by the opposite clock domain and passes it through a two-stage synchronizer. It then compares that pointer against the local `ptr_gen` `ptr_next` and produces the registered `flag` (empty on the read side, full on the write side) that gates `ptr_gen`. It also outputs a registered fill level and an almost-empty/almost-full indication. One instance runs in each clock domain; `MODE` selects the role.

## Interface
- `DEPTH`, 8: pointer range. Power of two, ≥4. Pointer width is PW = $clog2(DEPTH). Memory holds DEPTH/2 entries.
- `MODE`, 0: 0 = read side (empty flag); 1 = write side (full flag).
- `THRESH`, 1: almost-flag threshold, 0..DEPTH/2.

Ports:
- `clock`  in  1  local domain clock. Single clock domain.
- `resetn`  in  1  reset, synchronous, active-low.
- `ptr_next`  in  PW  local next Gray pointer from `ptr_gen` `ptr_next`.
- `ptr_remote`  in  PW  Gray pointer from the other domain's `ptr_gen` `ptr`. Asynchronous to `clock`.
- `flag`  out  1  registered empty (MODE=0) or full (MODE=1). Connects to `ptr_gen` `flag`.
- `almost`  out  1  registered almost-empty (MODE=0) or almost-full (MODE=1).
- `level`  out  PW  registered occupancy, 0..DEPTH/2.

## Operation
- Synchronizer: `sync1 <= ptr_remote`, then `sync2 <= sync1`. Both registers reset to 0. No logic sits between the two stages.
- Gray-to-binary conversion is combinational:
  - b[PW-1] = g[PW-1]
  - b[i] = b[i+1] ^ g[i]
  - Applied to `ptr_next` (giving lbin) and to `sync2` (giving rbin).
- Occupancy, computed modulo 2^PW:
  - MODE=0: occ = rbin − lbin.
  - MODE=1: occ = lbin − rbin.
  - Result is PW bits. Wrap-around needs no special casing.
- Flag, compared directly on Gray values:
  - MODE=0: empty_next = (ptr_next == sync2).
  - MODE=1: full_next = (ptr_next == {~sync2[PW-1], ~sync2[PW-2], sync2[PW-3:0]}). When PW=2, both bits are inverted.
- Almost flag:
  - MODE=0: occ ≤ THRESH.
  - MODE=1: occ ≥ DEPTH/2 − THRESH.
- Registers: `flag`, `almost` and `level` register their next values every cycle. There is no enable.
- Flags are conservative.
  - The remote pointer lags, so empty/full may stay asserted up to 3 cycles longer than the true state.
  - Empty/full is never deasserted early.
- Reset values:
  - `level` = 0.
  - MODE=0: `flag` = 1, `almost` = 1.
  - MODE=1: `flag` = 0, `almost` = (THRESH ≥ DEPTH/2).
- Reset mid-operation: on the first edge with resetn=0, all registers return to their reset values, regardless of the inputs. Both domains must be reset together; a one-sided reset is out of scope.
- `ptr_remote` is Gray-coded and changes at most 1 bit per remote clock. A sampled value is therefore either the old pointer or the new one.

## Timing
- Local path:
  - `ptr_next` changes combinationally in the cycle `inc` is accepted.
  - `flag`, `level` and `almost` reflect it after the same clock edge that updates `ptr_gen.ptr`.
  - Latency is 1 edge. This is what prevents overflow/underflow on back-to-back `inc`.
- Remote path: a change on `ptr_remote` reaches `sync1` at edge 1 and `sync2` at edge 2, and the outputs at edge 3. Latency is 3 local edges.
- Simultaneous local and remote changes: both are applied. The local effect appears 2 edges before the remote effect.
- Write side (MODE=1): `level` never exceeds DEPTH/2, provided `inc` is gated by `flag`.

## Test plan
All scenarios use DEPTH=8 (PW=3, 4 entries) and THRESH=1.

1. Reset:
   - Stimulus: drive resetn=0 for 1 edge, with arbitrary values on `ptr_next` and `ptr_remote`.
   - Required, MODE=0: `flag`=1, `almost`=1, `level`=0.
   - Required, MODE=1: `flag`=0, `almost`=0, `level`=0.
2. MODE=1 fill:
   - Stimulus: hold `ptr_remote`=000. Step `ptr_next` one value per cycle through 001, 011, 010, 110.
   - Required: `level` reads 1, 2, 3, 4 one edge after each step. `almost` rises when `level`=3. `flag` rises when `level`=4.
3. MODE=0 remote arrival:
   - Stimulus: hold `ptr_next`=000. Switch `ptr_remote` 000→001 (bin 1), then 011 (bin 2) one cycle later.
   - Required: `flag` falls exactly 3 edges after the first change, with `level`=1 and `almost`=1. One edge later, `level`=2 and `almost`=0.
4. Wrap-around, MODE=0:
   - Stimulus: `ptr_next` = `ptr_remote` = 100 (bin 7), so `flag`=1. Then set `ptr_remote`=000 (bin 0).
   - Required: after 3 edges, `level`=1 and `flag`=0.
   - Stimulus: then set `ptr_next`=000.
   - Required: next edge, `level`=0 and `flag`=1.
5. Simultaneous change, MODE=1:
   - Stimulus: start at `level`=2 (lbin 2, rbin 0). In the same cycle, advance both `ptr_next` to 010 and `ptr_remote` to 001.
   - Required: `level`=3 after 1 edge, and `level`=2 after edge 3. `flag` stays 0 throughout.
6. Reset mid-operation:
   - Stimulus: MODE=1 at `level`=4 with `flag`=1. Assert resetn=0 for 1 edge, with `ptr_next` held at 110.
   - Required: `flag`=0 and `level`=0 after that edge, and `sync1`/`sync2` read 0.
